// File: rtl/split_counter_if.sv
// Control and status bundle for split_counter: increment/load requests in,
// registered count and trigger status out.
interface split_counter_if #(
  parameter int unsigned CW = 4
) ();
  logic          en;
  logic          load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] count;
  logic          wrap;
  logic          trigger;
  logic          fired;

  modport master (
    output en, load, load_val,
    input  count, wrap, trigger, fired
  );

  modport slave (
    input  en, load, load_val,
    output count, wrap, trigger, fired
  );
endinterface

// File: rtl/split_counter.sv
// Segmented up-counter held as per-segment registers with a combinational or
// registered carry chain, plus a one-shot trigger on reaching TRIGGER_VALUE.
module split_counter #(
  parameter int unsigned SEG_WIDTH     = 2,
  parameter int unsigned NUM_SEGS      = 2,
  parameter int unsigned CARRY_REG     = 0,
  localparam int unsigned CW           = SEG_WIDTH * NUM_SEGS,
  parameter logic [CW-1:0] TRIGGER_VALUE = {CW{1'b1}}
) (
  input logic           clk,
  input logic           reset,
  split_counter_if.slave bus
);

  localparam int NSeg = int'(NUM_SEGS);
  localparam int unsigned NumCarry = (NUM_SEGS > 1) ? NUM_SEGS - 1 : 1;
  localparam logic [SEG_WIDTH-1:0] SegOnes = '1;
  localparam logic [SEG_WIDTH-1:0] SegOne  = SEG_WIDTH'(1);

  logic [SEG_WIDTH-1:0] seg_q [NUM_SEGS];
  logic [SEG_WIDTH-1:0] seg_d [NUM_SEGS];
  logic [NUM_SEGS-1:0]  inc;
  logic [NUM_SEGS-1:0]  at_ones;
  logic [NumCarry-1:0]  carry_q, carry_d;
  logic                 wrap_q, wrap_d;
  logic                 trigger_q, fired_q, match_prev_q;
  logic                 match;
  logic [CW-1:0]        count;

  always_comb begin
    logic ripple;
    inc     = '0;
    at_ones = '0;
    carry_d = '0;
    count   = '0;
    ripple  = bus.en & ~bus.load;
    for (int i = 0; i < NSeg; i++) begin
      at_ones[i] = (seg_q[i] == SegOnes);
      // Registered mode: upper segments step only on the stored carry, not on en.
      if (i > 0 && CARRY_REG != 0) begin
        inc[i] = carry_q[i-1] & ~bus.load;
      end else begin
        inc[i] = ripple;
      end
      ripple = ripple & at_ones[i];
    end
    for (int i = 0; i < NSeg - 1; i++) begin
      carry_d[i] = inc[i] & at_ones[i] & ~bus.load;
    end
    for (int i = 0; i < NSeg; i++) begin
      if (bus.load) begin
        seg_d[i] = bus.load_val[i*SEG_WIDTH +: SEG_WIDTH];
      end else if (inc[i]) begin
        seg_d[i] = seg_q[i] + SegOne;
      end else begin
        seg_d[i] = seg_q[i];
      end
      count[i*SEG_WIDTH +: SEG_WIDTH] = seg_q[i];
    end
    wrap_d = ~bus.load & inc[NUM_SEGS-1] & at_ones[NUM_SEGS-1];
    match  = (count == TRIGGER_VALUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSeg; i++) begin
        seg_q[i] <= '0;
      end
      carry_q      <= '0;
      wrap_q       <= 1'b0;
      trigger_q    <= 1'b0;
      fired_q      <= 1'b0;
      // A zero trigger value must not fire straight out of reset.
      match_prev_q <= (TRIGGER_VALUE == '0);
    end else begin
      for (int i = 0; i < NSeg; i++) begin
        seg_q[i] <= seg_d[i];
      end
      carry_q      <= carry_d;
      wrap_q       <= wrap_d;
      match_prev_q <= match;
      trigger_q    <= match & ~match_prev_q;
      fired_q      <= fired_q | (match & ~match_prev_q);
    end
  end

  assign bus.count   = count;
  assign bus.wrap    = wrap_q;
  assign bus.trigger = trigger_q;
  assign bus.fired   = fired_q;

endmodule

// File: tb/tb_split_counter.sv
// Scoreboard bench for split_counter: three configurations (ripple 2x2,
// registered-carry 2x2, ripple 4x3 with zero trigger) driven by directed vectors.
module tb_split_counter;

  typedef struct {
    int          id;
    string       name;
    logic [11:0] count;
    logic        wrap;
    logic        trig;
    logic        fired;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   errors;
  int   checks;

  split_counter_if #(.CW(4))  if0 ();
  split_counter_if #(.CW(4))  if1 ();
  split_counter_if #(.CW(12)) if2 ();

  split_counter #(
    .SEG_WIDTH(2), .NUM_SEGS(2), .CARRY_REG(0), .TRIGGER_VALUE(4'd15)
  ) u_comb (
    .clk(clk), .reset(reset), .bus(if0)
  );

  split_counter #(
    .SEG_WIDTH(2), .NUM_SEGS(2), .CARRY_REG(1), .TRIGGER_VALUE(4'd15)
  ) u_reg (
    .clk(clk), .reset(reset), .bus(if1)
  );

  split_counter #(
    .SEG_WIDTH(3), .NUM_SEGS(4), .CARRY_REG(0), .TRIGGER_VALUE(12'd0)
  ) u_wide (
    .clk(clk), .reset(reset), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sample(input int id, output logic [11:0] c, output logic w,
                        output logic t, output logic f);
    case (id)
      0:       begin c = {8'd0, if0.count}; w = if0.wrap; t = if0.trigger; f = if0.fired; end
      1:       begin c = {8'd0, if1.count}; w = if1.wrap; t = if1.trigger; f = if1.fired; end
      default: begin c = if2.count; w = if2.wrap; t = if2.trigger; f = if2.fired; end
    endcase
  endtask

  // Monitor: pops one expectation per clock, just after the edge that produced it.
  initial begin
    exp_t        e;
    logic [11:0] c;
    logic        w, t, f;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        sample(e.id, c, w, t, f);
        checks++;
        if (c !== e.count || w !== e.wrap || t !== e.trig || f !== e.fired) begin
          errors++;
          $display("FAIL %s (dut%0d): got count=%0d wrap=%b trig=%b fired=%b, want count=%0d wrap=%b trig=%b fired=%b",
                   e.name, e.id, c, w, t, f, e.count, e.wrap, e.trig, e.fired);
        end
      end
    end
  end

  task automatic clear_inputs();
    if0.en = 1'b0; if0.load = 1'b0; if0.load_val = '0;
    if1.en = 1'b0; if1.load = 1'b0; if1.load_val = '0;
    if2.en = 1'b0; if2.load = 1'b0; if2.load_val = '0;
  endtask

  task automatic step(input int id, input logic e, input logic l, input logic [11:0] v,
                      input string nm, input logic [11:0] c, input logic w,
                      input logic t, input logic f);
    exp_t x;
    @(negedge clk);
    clear_inputs();
    case (id)
      0:       begin if0.en = e; if0.load = l; if0.load_val = v[3:0]; end
      1:       begin if1.en = e; if1.load = l; if1.load_val = v[3:0]; end
      default: begin if2.en = e; if2.load = l; if2.load_val = v; end
    endcase
    x.id = id; x.name = nm; x.count = c; x.wrap = w; x.trig = t; x.fired = f;
    q.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk);
    #2;
    while (q.size() > 0 && n < 4) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      q.delete();
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic chk_state(input int id, input string nm, input logic [11:0] c,
                           input logic w, input logic t, input logic f);
    logic [11:0] ac;
    logic        aw, at, af;
    sample(id, ac, aw, at, af);
    checks++;
    if (ac !== c || aw !== w || at !== t || af !== f) begin
      errors++;
      $display("FAIL %s (dut%0d): got count=%0d wrap=%b trig=%b fired=%b, want count=%0d wrap=%b trig=%b fired=%b",
               nm, id, ac, aw, at, af, c, w, t, f);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk_state(d, "reset_state", 12'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int c1 [18] = '{1, 2, 3, 0, 5, 6, 7, 4, 9, 10, 11, 8, 13, 14, 15, 12, 1, 2};

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    do_reset();

    // Ripple mode: 0..15, trigger and wrap together on the edge after 15.
    for (int k = 1; k <= 17; k++) begin
      step(0, 1'b1, 1'b0, 12'd0, "comb_count", 12'(k % 16), k == 16, k == 16, k >= 16);
    end
    drain();

    // Load 14, count through 15, then a held load of 15 fires once only.
    do_reset();
    step(0, 1'b0, 1'b1, 12'd14, "load14",      12'd14, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 12'd0,  "to15",        12'd15, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 12'd0,  "roll_trig",   12'd0,  1'b1, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0, 12'd0,  "after_roll",  12'd1,  1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 12'd15, "load15_en",   12'd15, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 12'd0,  "load15_trig", 12'd15, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 12'd0,  "hold15_a",    12'd15, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 12'd0,  "hold15_b",    12'd15, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 12'd0,  "leave15",     12'd0,  1'b1, 1'b0, 1'b1);
    drain();

    // Registered carry: upper segment lags one edge per seg0 rollover.
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      step(1, 1'b1, 1'b0, 12'd0, "reg_count", 12'(c1[k-1]), k == 17, k == 16, k >= 16);
    end
    drain();

    // Load coincident with a pending carry discards the carry.
    do_reset();
    step(1, 1'b1, 1'b0, 12'd0, "rc_1",      12'd1, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 12'd0, "rc_2",      12'd2, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 12'd0, "rc_3",      12'd3, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 12'd0, "rc_pend",   12'd0, 1'b0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, 12'd8, "rc_load8",  12'd8, 1'b0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 12'd0, "rc_hold_a", 12'd8, 1'b0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 12'd0, "rc_hold_b", 12'd8, 1'b0, 1'b0, 1'b0);
    drain();

    // Async reset with a carry pending and fired set.
    do_reset();
    step(1, 1'b0, 1'b1, 12'd15, "ar_load15", 12'd15, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 12'd0,  "ar_pend",   12'd12, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL ar_queue: got %0d pending, want 0", q.size());
      q.delete();
    end
    clear_inputs();
    #1;
    reset = 1'b1;
    #1;
    chk_state(1, "async_reset", 12'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 1'b0, 1'b0, 12'd0, "ar_idle_a", 12'd0, 1'b0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 12'd0, "ar_idle_b", 12'd0, 1'b0, 1'b0, 1'b0);
    drain();

    // Wide counter, zero trigger: no fire out of reset; fires after the wrap to 0.
    do_reset();
    for (int k = 1; k <= 4097; k++) begin
      step(2, 1'b1, 1'b0, 12'd0, "wide_count", 12'(k % 4096), k == 4096, k == 4097, k >= 4097);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
